// File: rtl/daio_subframe_rx.sv
// Digital-audio receive framer: assembles decoded biphase bits into subframes
// A/B, checks even parity, tracks the frame position inside the block, gathers
// the channel-status bits and keeps sticky line-error status.
//
// Strobe semantics: every *_valid / preamble / biphase_violation / status_clear
// input is a one-cycle qualifier sampled on the rising clock edge; there is no
// back-pressure. out_valid, cs_valid and block_start are one-cycle pulses and
// the values they qualify are held until the next pulse.
module daio_subframe_rx #(
    parameter int DATA_W           = 24,
    parameter int FRAMES_PER_BLOCK = 192,
    parameter int CS_BITS          = 32,
    parameter int PERR_W           = 8
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic                                bit_valid,
    input  logic                                bit_in,
    input  logic                                preamble_1,
    input  logic                                preamble_2,
    input  logic                                preamble_3,
    input  logic                                carrier_loss,
    input  logic                                biphase_violation,
    input  logic                                status_clear,
    output logic [DATA_W-1:0]                   data_out,
    output logic                                out_valid,
    output logic                                out_chan,
    output logic                                out_v,
    output logic                                out_perr,
    output logic [$clog2(FRAMES_PER_BLOCK)-1:0] frame_ofs,
    output logic                                block_start,
    output logic [CS_BITS-1:0]                  cs_word,
    output logic                                cs_valid,
    output logic [3:0]                          rx_status,
    output logic [PERR_W-1:0]                   perr_count,
    output logic [2:0]                          dbg_state
);

    localparam int SF_W  = DATA_W + 4;          // audio + V, U, C, P
    localparam int CNT_W = $clog2(SF_W + 1);
    localparam int FW    = $clog2(FRAMES_PER_BLOCK);
    localparam int C_IDX = DATA_W + 2;          // position of the C bit

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RECV_A = 3'd1,
        S_RECV_B = 3'd2,
        S_DONE_A = 3'd3,
        S_DONE_B = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SF_W-2:0]     sr_q, sr_d;            // every bit except P, LSB first
    logic                par_q, par_d;
    logic                a_done_q, a_done_d;    // an A subframe just completed
    logic [FW-1:0]       frame_q, frame_d;
    logic                wrapped_q, wrapped_d;  // frame counter wrapped, awaiting preamble_1
    logic [CS_BITS-1:0]  shadow_q, shadow_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ov_q, ov_d;
    logic                chan_q, chan_d;
    logic                v_q, v_d;
    logic                perr_q, perr_d;
    logic                bs_q, bs_d;
    logic [CS_BITS-1:0]  cs_word_q, cs_word_d;
    logic                cs_valid_q, cs_valid_d;
    logic [3:0]          status_q, status_d;
    logic [PERR_W-1:0]   perr_cnt_q, perr_cnt_d;

    logic pre_multi, pre_one, receiving, sync_err, parity_fail;

    // Next-state, datapath and status logic for the whole framer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        par_d       = par_q;
        a_done_d    = a_done_q;
        frame_d     = frame_q;
        wrapped_d   = wrapped_q;
        shadow_d    = shadow_q;
        data_d      = data_q;
        ov_d        = 1'b0;
        chan_d      = chan_q;
        v_d         = v_q;
        perr_d      = perr_q;
        bs_d        = 1'b0;
        cs_word_d   = cs_word_q;
        cs_valid_d  = 1'b0;
        status_d    = status_clear ? 4'b0000 : status_q;
        perr_cnt_d  = status_clear ? '0 : perr_cnt_q;
        sync_err    = 1'b0;
        parity_fail = 1'b0;

        pre_multi = (preamble_1 & preamble_2) | (preamble_1 & preamble_3) |
                    (preamble_2 & preamble_3);
        pre_one   = (preamble_1 | preamble_2 | preamble_3) & ~pre_multi;
        receiving = (state_q == S_RECV_A) || (state_q == S_RECV_B);

        if (carrier_loss) status_d[0] = 1'b1;

        if (!enable) begin
            // Silent abort: no sync error, frame position untouched.
            state_d  = S_IDLE;
            cnt_d    = '0;
            a_done_d = 1'b0;
        end else begin
            if (biphase_violation) status_d[1] = 1'b1;
            if (pre_multi) sync_err = 1'b1;

            if (pre_one) begin
                // A preamble always restarts reception; any bit this cycle is dropped.
                if (receiving && (cnt_q != '0)) sync_err = 1'b1;
                cnt_d    = '0;
                par_d    = 1'b0;
                a_done_d = 1'b0;
                if (preamble_1) begin
                    state_d   = S_RECV_A;
                    frame_d   = '0;
                    wrapped_d = 1'b0;
                    shadow_d  = '0;
                    bs_d      = 1'b1;
                end else if (preamble_2) begin
                    state_d = S_RECV_A;
                    if (wrapped_q && (frame_q == '0)) sync_err = 1'b1;
                    wrapped_d = 1'b0;
                end else if (a_done_q) begin
                    state_d = S_RECV_B;
                end else begin
                    state_d  = S_IDLE;
                    sync_err = 1'b1;
                end
            end else if (receiving && bit_valid) begin
                cnt_d = cnt_q + 1'b1;
                par_d = par_q ^ bit_in;
                sr_d  = {bit_in, sr_q[SF_W-2:1]};
                if ((state_q == S_RECV_A) && (cnt_q == CNT_W'(C_IDX))) begin
                    for (int i = 0; i < CS_BITS; i++) begin
                        if (frame_q == FW'(i)) shadow_d[i] = bit_in;
                    end
                end
                if (cnt_q == CNT_W'(SF_W - 1)) begin
                    // This strobe carries P: the subframe is complete.
                    ov_d   = 1'b1;
                    data_d = sr_q[DATA_W-1:0];
                    v_d    = sr_q[DATA_W];
                    perr_d = par_q ^ bit_in;
                    parity_fail = par_q ^ bit_in;
                    if (state_q == S_RECV_A) begin
                        state_d  = S_DONE_A;
                        chan_d   = 1'b0;
                        a_done_d = 1'b1;
                        if (frame_q == FW'(CS_BITS - 1)) begin
                            cs_word_d  = shadow_q;
                            cs_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = S_DONE_B;
                        chan_d  = 1'b1;
                        if (frame_q == FW'(FRAMES_PER_BLOCK - 1)) begin
                            frame_d   = '0;
                            wrapped_d = 1'b1;
                        end else begin
                            frame_d = frame_q + 1'b1;
                        end
                    end
                end
            end else if ((state_q == S_DONE_A) || (state_q == S_DONE_B)) begin
                state_d = S_IDLE;
            end
        end

        if (sync_err) status_d[3] = 1'b1;
        if (parity_fail) begin
            status_d[2] = 1'b1;
            if (perr_cnt_d != '1) perr_cnt_d = perr_cnt_d + 1'b1;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            par_q      <= 1'b0;
            a_done_q   <= 1'b0;
            frame_q    <= '0;
            wrapped_q  <= 1'b0;
            shadow_q   <= '0;
            data_q     <= '0;
            ov_q       <= 1'b0;
            chan_q     <= 1'b0;
            v_q        <= 1'b0;
            perr_q     <= 1'b0;
            bs_q       <= 1'b0;
            cs_word_q  <= '0;
            cs_valid_q <= 1'b0;
            status_q   <= 4'b0000;
            perr_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            par_q      <= par_d;
            a_done_q   <= a_done_d;
            frame_q    <= frame_d;
            wrapped_q  <= wrapped_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            ov_q       <= ov_d;
            chan_q     <= chan_d;
            v_q        <= v_d;
            perr_q     <= perr_d;
            bs_q       <= bs_d;
            cs_word_q  <= cs_word_d;
            cs_valid_q <= cs_valid_d;
            status_q   <= status_d;
            perr_cnt_q <= perr_cnt_d;
        end
    end

    assign data_out    = data_q;
    assign out_valid   = ov_q;
    assign out_chan    = chan_q;
    assign out_v       = v_q;
    assign out_perr    = perr_q;
    assign frame_ofs   = frame_q;
    assign block_start = bs_q;
    assign cs_word     = cs_word_q;
    assign cs_valid    = cs_valid_q;
    assign rx_status   = status_q;
    assign perr_count  = perr_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_daio_subframe_rx.sv
// Directed bench for daio_subframe_rx (DATA_W=24, 192 frames, 32 CS bits,
// 2-bit parity-error counter so saturation is reachable).
module tb_daio_subframe_rx;

    localparam int DATA_W = 24;
    localparam int FPB    = 192;
    localparam int CSB    = 32;
    localparam int PERR_W = 2;

    logic              clock, reset_n, enable, bit_valid, bit_in;
    logic              preamble_1, preamble_2, preamble_3;
    logic              carrier_loss, biphase_violation, status_clear;
    logic [DATA_W-1:0] data_out;
    logic              out_valid, out_chan, out_v, out_perr;
    logic [7:0]        frame_ofs;
    logic              block_start;
    logic [CSB-1:0]    cs_word;
    logic              cs_valid;
    logic [3:0]        rx_status;
    logic [PERR_W-1:0] perr_count;
    logic [2:0]        dbg_state;

    int checks   = 0;
    int failures = 0;
    int ov_cnt   = 0;
    int cs_cnt   = 0;
    int mark;
    logic [DATA_W-1:0] exp_q[$];

    daio_subframe_rx #(
        .DATA_W(DATA_W), .FRAMES_PER_BLOCK(FPB), .CS_BITS(CSB), .PERR_W(PERR_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .bit_valid(bit_valid), .bit_in(bit_in),
        .preamble_1(preamble_1), .preamble_2(preamble_2), .preamble_3(preamble_3),
        .carrier_loss(carrier_loss), .biphase_violation(biphase_violation),
        .status_clear(status_clear),
        .data_out(data_out), .out_valid(out_valid), .out_chan(out_chan),
        .out_v(out_v), .out_perr(out_perr), .frame_ofs(frame_ofs),
        .block_start(block_start), .cs_word(cs_word), .cs_valid(cs_valid),
        .rx_status(rx_status), .perr_count(perr_count), .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected sample.
    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            ov_cnt++;
            if (exp_q.size() == 0) check("unexpected_out_valid", 64'(data_out), 64'hDEAD_BEEF);
            else                   check("sb_data", 64'(data_out), 64'(exp_q.pop_front()));
        end
        if (reset_n && cs_valid) cs_cnt++;
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pre(input int k);
        preamble_1 = (k == 1);
        preamble_2 = (k == 2);
        preamble_3 = (k == 3);
        tick();
        preamble_1 = 1'b0;
        preamble_2 = 1'b0;
        preamble_3 = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Sends the first n bits of a subframe {P, C, U=0, V=0, data}; P gives even
    // parity unless bad is set. A full subframe is posted to the scoreboard.
    task automatic send_bits(input int n, input logic [DATA_W-1:0] d, input logic c,
                             input logic bad);
        logic [27:0] w;
        w = {(^{c, d}) ^ bad, c, 1'b0, 1'b0, d};
        if (n == 28) exp_q.push_back(d);
        for (int i = 0; i < n; i++) send_bit(w[i]);
    endtask

    task automatic clear_status();
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
        preamble_1 = 1'b0; preamble_2 = 1'b0; preamble_3 = 1'b0;
        carrier_loss = 1'b0; biphase_violation = 1'b0; status_clear = 1'b0;
        tick(); tick();

        // Reset state.
        check("rst_data_out", 64'(data_out), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_frame_ofs", 64'(frame_ofs), 64'h0);
        check("rst_cs_word", 64'(cs_word), 64'h0);
        check("rst_rx_status", 64'(rx_status), 64'h0);
        check("rst_state", 64'(dbg_state), 64'h0);
        reset_n = 1'b1;
        tick();

        // Block start and a clean subframe A.
        pre(1);
        check("t1_block_start", 64'(block_start), 64'h1);
        check("t1_frame_ofs", 64'(frame_ofs), 64'h0);
        send_bits(28, 24'hA5A5A5, 1'b1, 1'b0);
        check("t1_out_valid", 64'(out_valid), 64'h1);
        check("t1_data", 64'(data_out), 64'hA5A5A5);
        check("t1_chan", 64'(out_chan), 64'h0);
        check("t1_perr", 64'(out_perr), 64'h0);
        check("t1_v", 64'(out_v), 64'h0);
        check("t1_bs_low", 64'(block_start), 64'h0);

        // Subframe B with wrong parity.
        pre(3);
        send_bits(28, 24'h123456, 1'b0, 1'b1);
        check("t2_out_valid", 64'(out_valid), 64'h1);
        check("t2_chan", 64'(out_chan), 64'h1);
        check("t2_perr", 64'(out_perr), 64'h1);
        check("t2_rx_status", 64'(rx_status), 64'h4);
        check("t2_perr_count", 64'(perr_count), 64'h1);
        check("t2_frame_ofs", 64'(frame_ofs), 64'h1);
        tick();
        check("t2_ov_pulse", 64'(out_valid), 64'h0);
        check("t2_data_hold", 64'(data_out), 64'h123456);

        // Preamble in the middle of A aborts it with a sync error.
        clear_status();
        check("t3_cleared", 64'(rx_status), 64'h0);
        mark = ov_cnt;
        pre(2);
        send_bits(10, 24'hFFFFFF, 1'b0, 1'b0);
        pre(2);
        check("t3_no_ov", 64'(ov_cnt), 64'(mark));
        send_bits(28, 24'h0F0F0F, 1'b0, 1'b0);
        check("t3_out_valid", 64'(out_valid), 64'h1);
        check("t3_data", 64'(data_out), 64'h0F0F0F);
        check("t3_perr", 64'(out_perr), 64'h0);
        check("t3_rx_status", 64'(rx_status), 64'h8);

        // Parity counter saturation and clearing.
        clear_status();
        for (int i = 0; i < 5; i++) begin
            pre(2);
            send_bits(28, 24'(i * 3 + 1), 1'b0, 1'b1);
        end
        check("t4_perr_sat", 64'(perr_count), 64'h3);
        check("t4_rx_status", 64'(rx_status), 64'h4);
        status_clear = 1'b1;
        carrier_loss = 1'b1;
        tick();
        status_clear = 1'b0;
        carrier_loss = 1'b0;
        check("t4_clear_vs_new", 64'(rx_status), 64'h1);
        check("t4_perr_cleared", 64'(perr_count), 64'h0);
        clear_status();
        check("t4_all_clear", 64'(rx_status), 64'h0);

        // Full block: C of A = frame bit 0.
        mark = cs_cnt;
        for (int f = 0; f < FPB; f++) begin
            pre((f == 0) ? 1 : 2);
            send_bits(28, 24'(f * 4099 + 7), f[0], 1'b0);
            if (f == 30) check("t5_cs_not_yet", 64'(cs_valid), 64'h0);
            if (f == 31) begin
                check("t5_cs_valid", 64'(cs_valid), 64'h1);
                check("t5_cs_word", 64'(cs_word), 64'hAAAA_AAAA);
            end
            pre(3);
            send_bits(28, 24'(~(f * 4099)), 1'b0, 1'b0);
            if (f == FPB - 2) check("t5_frame_last", 64'(frame_ofs), 64'd191);
            if (f == FPB - 1) check("t5_frame_wrap", 64'(frame_ofs), 64'h0);
        end
        check("t5_cs_count", 64'(cs_cnt - mark), 64'h1);
        check("t5_rx_status", 64'(rx_status), 64'h0);
        check("t5_perr_count", 64'(perr_count), 64'h0);

        // Wrap followed by preamble_2 instead of preamble_1.
        pre(2);
        send_bits(28, 24'h00FFEE, 1'b1, 1'b0);
        check("t6_out_valid", 64'(out_valid), 64'h1);
        check("t6_sync_err", 64'(rx_status), 64'h8);
        check("t6_frame_ofs", 64'(frame_ofs), 64'h0);

        // Asynchronous reset in the middle of subframe B.
        pre(3);
        send_bits(10, 24'h777777, 1'b0, 1'b0);
        reset_n = 1'b0;
        #2;
        check("t7_rst_data", 64'(data_out), 64'h0);
        check("t7_rst_status", 64'(rx_status), 64'h0);
        check("t7_rst_cs_word", 64'(cs_word), 64'h0);
        check("t7_rst_state", 64'(dbg_state), 64'h0);
        check("t7_rst_chan", 64'(out_chan), 64'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        pre(1);
        send_bits(28, 24'h5A5A5A, 1'b0, 1'b0);
        check("t7_out_valid", 64'(out_valid), 64'h1);
        check("t7_data", 64'(data_out), 64'h5A5A5A);
        check("t7_chan", 64'(out_chan), 64'h0);
        check("t7_perr", 64'(out_perr), 64'h0);
        check("t7_frame_ofs", 64'(frame_ofs), 64'h0);

        tick(); tick();
        check("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
